// File: rtl/led_prog_loader_if.sv
// Byte-stream / program-memory bus for the LED CPU program loader.
// Carries the incoming valid/ready byte stream and the word write port that
// fills the CPU program memory.
//   in_valid  : byte available on in_data          (source -> loader)
//   in_data   : stream byte                        (source -> loader)
//   in_ready  : loader accepts byte this cycle     (loader -> source)
//   mem_we    : program memory write strobe        (loader -> memory)
//   mem_addr  : program memory word address        (loader -> memory)
//   mem_wdata : program memory word, big-endian    (loader -> memory)
// Modports: master = byte source / memory side, slave = loader.
interface led_prog_loader_if #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned WORD_BYTES = 2
);
  localparam int unsigned DATA_W = 8 * WORD_BYTES;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/led_prog_loader.sv
// led_prog_loader: program loader for the LED CPU.
// Receives a framed instruction image over a valid/ready byte stream and writes
// it word-by-word into the CPU program memory, holding the CPU in reset until a
// complete, valid image has been committed.
// Frame: 0xA5 (SOF), LEN (word count N), N*WORD_BYTES data bytes, [CSUM].
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-low reset
//   bus      : led_prog_loader_if.slave (byte stream in, memory write port out)
//   cpu_hold : 1 = keep CPU in reset
//   busy     : frame in progress
//   done     : image committed (sticky until next SOF)
//   err      : frame rejected (sticky until next SOF)
// Configuration macro: LOADER_CHECKSUM_EN -- when defined a trailing CSUM byte
// is required; LEN + data + CSUM must sum to 0x00 mod 256.
module led_prog_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned WORD_BYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  led_prog_loader_if.slave    bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int unsigned DATA_W  = 8 * WORD_BYTES;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned BC_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned CAP     = (ADDR_W >= 8) ? 255 : (1 << ADDR_W);
  localparam logic [8:0]  MAX_LEN = 9'(CAP);
  localparam logic [7:0]  SOF     = 8'hA5;

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t            state, stateNext;
  logic              readyQ;
  logic [7:0]        lenQ;
  logic [CNT_W-1:0]  wordCnt;
  logic [BC_W-1:0]   byteCnt;
  logic [DATA_W-1:0] asmQ;
  logic [DATA_W-1:0] asmNext;
  logic [DATA_W+7:0] shiftCat;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;

  logic              xfer;
  logic              isSof;
  logic              lenBad;
  logic [8:0]        lenExt;
  logic              lastByte;
  logic              lastWord;

  assign xfer     = bus.in_valid & readyQ;
  assign isSof    = (bus.in_data == SOF);
  assign lenExt   = {1'b0, bus.in_data};
  assign lenBad   = (bus.in_data == 8'h00) || (lenExt > MAX_LEN);
  assign lastByte = (byteCnt == BC_W'(WORD_BYTES - 1));
  assign lastWord = (wordCnt == (CNT_W'(lenQ) - CNT_W'(1)));
  // Big-endian assembly: earlier bytes migrate toward the MSBs.
  assign shiftCat = {asmQ, bus.in_data};
  assign asmNext  = shiftCat[DATA_W-1:0];

  assign bus.in_ready  = readyQ;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sumQ;
  logic [7:0] sumNext;

  assign sumNext = sumQ + bus.in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sumQ <= '0;
    end else if (xfer) begin
      if (state == LEN) begin
        sumQ <= bus.in_data;
      end else if (state == DATA || state == CSUM) begin
        sumQ <= sumNext;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    cpu_hold  = (state != DONE);
    busy      = (state == LEN) || (state == DATA) || (state == CSUM);
    done      = (state == DONE);
    err       = (state == ERR);
    unique case (state)
      IDLE, DONE, ERR: begin
        if (xfer && isSof) stateNext = LEN;
      end
      LEN: begin
        if (xfer) stateNext = lenBad ? ERR : DATA;
      end
      DATA: begin
        if (xfer && lastByte && lastWord) begin
`ifdef LOADER_CHECKSUM_EN
          stateNext = CSUM;
`else
          stateNext = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) stateNext = (sumNext == 8'h00) ? DONE : ERR;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: counters, word assembly and the registered memory write port.
  // The write strobe is issued from the register stage so the full word and
  // its address appear together the cycle after the completing byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readyQ   <= 1'b0;
      lenQ     <= '0;
      wordCnt  <= '0;
      byteCnt  <= '0;
      asmQ     <= '0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
    end else begin
      readyQ <= 1'b1;
      memWe  <= 1'b0;
      if (xfer) begin
        if (state == LEN) begin
          lenQ    <= bus.in_data;
          wordCnt <= '0;
          byteCnt <= '0;
          memAddr <= '0;
        end else if (state == DATA) begin
          asmQ <= asmNext;
          if (lastByte) begin
            byteCnt  <= '0;
            wordCnt  <= wordCnt + CNT_W'(1);
            memWe    <= 1'b1;
            memAddr  <= wordCnt[ADDR_W-1:0];
            memWdata <= asmNext;
          end else begin
            byteCnt <= byteCnt + BC_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_led_prog_loader.sv
// Self-checking bench for led_prog_loader: directed and randomized frames,
// expected memory writes kept in a scoreboard queue, expected status kept by a
// frame-level reference model.
module tb_led_prog_loader;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic rst;
  logic cpuHold, busy, done, err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  wr_t expQ[$];
  logic expDone = 1'b0;
  logic expErr  = 1'b0;
  logic prevWe  = 1'b0;

  led_prog_loader_if #(.ADDR_W(8), .WORD_BYTES(2)) bus ();

  led_prog_loader #(.ADDR_W(8), .WORD_BYTES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cpu_hold (cpuHold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      if (prevWe) begin
        checks++;
        errors++;
        $display("FAIL we_pulse: mem_we high %0d cycles expected 1", 2);
      end
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = expQ.pop_front();
        check("write_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("write_data", 32'(bus.mem_wdata), 32'(e.data));
      end
    end
    prevWe = (bus.mem_we === 1'b1);
  end

  // Frame-level reference: locate SOF, read N, slice out big-endian words,
  // then judge the whole frame by its byte sum.
  task automatic modelFrame(input bq_t f);
    int unsigned i = 0;
    int unsigned n;
    logic [7:0]  s;
    while (i < f.size() && f[i] != 8'hA5) i++;
    n = int'(f[i+1]);
    if (n == 0) begin
      expDone = 1'b0;
      expErr  = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++)
      expQ.push_back('{addr: 8'(w), data: {f[i+2+2*w], f[i+3+2*w]}});
    if (CSUM_ON) begin
      s = 8'h00;
      for (int k = i + 1; k <= i + 2 + 2 * n; k++) s = s + f[k];
      expDone = (s == 8'h00);
      expErr  = (s != 8'h00);
    end else begin
      expDone = 1'b1;
      expErr  = 1'b0;
    end
  endtask

  function automatic bq_t buildFrame(input int unsigned n, input bq_t dat, input bit badSum,
                                     input int unsigned junk);
    bq_t f;
    logic [7:0] s;
    logic [7:0] c;
    logic [7:0] g;
    for (int j = 0; j < int'(junk); j++) begin
      g = 8'($urandom_range(0, 255));
      f.push_back((g == 8'hA5) ? 8'h00 : g);
    end
    f.push_back(8'hA5);
    f.push_back(8'(n));
    if (n == 0) return f;
    s = 8'(n);
    foreach (dat[k]) begin
      f.push_back(dat[k]);
      s = s + dat[k];
    end
    if (CSUM_ON) begin
      c = ~s + 8'd1;
      if (badSum) c = c + 8'(1 + $urandom_range(0, 254));
      f.push_back(c);
    end
    return f;
  endfunction

  task automatic sendByte(input logic [7:0] b, input int unsigned gap);
    int unsigned k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=%0b expected 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkStatus(input string tag);
    check({tag, "_done"}, 32'(done), 32'(expDone));
    check({tag, "_err"}, 32'(err), 32'(expErr));
    check({tag, "_hold"}, 32'(cpuHold), 32'(!expDone));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pending"}, expQ.size(), 32'd0);
  endtask

  task automatic sendFrame(input string tag, input bq_t f, input int unsigned minGap,
                           input int unsigned maxGap);
    modelFrame(f);
    foreach (f[i]) sendByte(f[i], $urandom_range(minGap, maxGap));
    repeat (2) @(negedge clk);
    #2;
    checkStatus(tag);
  endtask

  task automatic checkResetVals(input string tag);
    check({tag, "_hold"}, 32'(cpuHold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    bq_t d;
    bq_t f;
    int unsigned n;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    #10;
    checkResetVals("rst_active");
    #20 rst = 1'b1;
    #1;
    checkResetVals("rst_first_cycle");
    @(negedge clk);
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);

    d = '{8'h12, 8'h34, 8'h56, 8'h78};
    sendFrame("good2", buildFrame(2, d, 1'b0, 0), 0, 0);

    d = '{8'hAA, 8'h55};
    sendFrame("badsum", buildFrame(1, d, 1'b1, 0), 0, 0);

    d = {};
    sendFrame("len0", buildFrame(0, d, 1'b0, 0), 0, 0);
    check("len0_no_write_err", 32'(err), 32'd1);
    d = '{8'h00, 8'hFF};
    sendFrame("after_len0", buildFrame(1, d, 1'b0, 0), 0, 0);

    d = '{8'hA5, 8'hA5};
    sendFrame("gaps_a5", buildFrame(1, d, 1'b0, 2), 3, 3);

    // Partial frame, then reset: the completed word is still written.
    expQ.push_back('{addr: 8'h00, data: 16'h1234});
    sendByte(8'hA5, 0);
    sendByte(8'h02, 0);
    sendByte(8'h12, 0);
    sendByte(8'h34, 1);
    rst = 1'b0;
    #2;
    checkResetVals("midframe_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expDone = 1'b0;
    expErr  = 1'b0;
    d = '{8'h9C, 8'h01, 8'hFE, 8'h77};
    sendFrame("after_rst", buildFrame(2, d, 1'b0, 0), 0, 1);

    d = {};
    for (int k = 0; k < 510; k++) d.push_back(8'($urandom_range(0, 255)));
    sendFrame("len255", buildFrame(255, d, 1'b0, 0), 0, 0);
    check("len255_last_addr", 32'(bus.mem_addr), 32'd254);

    for (int r = 0; r < 14; r++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      d = {};
      for (int k = 0; k < int'(2 * n); k++)
        d.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
      f = buildFrame(n, d, ($urandom_range(0, 2) == 0), $urandom_range(0, 2));
      sendFrame("random", f, 0, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
